// File: rtl/ysyx_22041461_ctrl_fsm_if.sv
// Instruction-fetch bus between the NPC sequencer and instruction memory.
// Ports: request channel (valid/ready, 64-bit address) and response channel
// (valid, 32-bit instruction, bus error). Modports: master = sequencer, slave = memory.
interface ysyx_22041461_ctrl_fsm_if;
  logic        ifu_req_valid;
  logic [63:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic        ifu_rsp_err;

  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, ifu_rsp_err
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, ifu_rsp_err
  );
endinterface

// File: rtl/ysyx_22041461_ctrl_fsm.sv
// Multi-cycle NPC sequencer: fetch -> decode sample -> execute (timed) -> writeback.
// Ports: clk/rst_n/run, ifu fetch bus (master), inst_q to IDU, dec_* from IDU,
// exu_start/exu_done to EXU, regw_en strobe, pc/retire_cnt/halted/halt_code status.
module ysyx_22041461_ctrl_fsm #(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter int          EXU_TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             run,
  ysyx_22041461_ctrl_fsm_if.master         ifu,
  output logic [31:0]                      inst_q,
  input  logic                             dec_en_regw,
  input  logic                             dec_illegal,
  input  logic                             dec_ebreak,
  output logic                             exu_start,
  input  logic                             exu_done,
  output logic                             regw_en,
  output logic [63:0]                      pc,
  output logic [63:0]                      retire_cnt,
  output logic                             halted,
  output logic [2:0]                       halt_code
);

  // Counter holds the 1-based EXEC cycle number; one spare value avoids
  // overflow on the cycle the timeout fires.
  localparam int           CW = $clog2(EXU_TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(EXU_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FREQ, S_FWAIT, S_DEC, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] ecnt;
  logic          wb_pending;

  logic          load_inst, latch_wb, pc_inc, retire_inc, halt_set;
  logic [2:0]    code_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      inst_q     <= 32'h0000_0013;
      retire_cnt <= 64'd0;
      halt_code  <= 3'd0;
      wb_pending <= 1'b0;
      ecnt       <= CW'(1);
    end else begin
      state <= state_d;
      if (load_inst)  inst_q     <= ifu.ifu_rsp_inst;
      if (latch_wb)   wb_pending <= dec_en_regw;
      if (pc_inc)     pc         <= pc + 64'd4;
      if (retire_inc) retire_cnt <= retire_cnt + 64'd1;
      if (halt_set)   halt_code  <= code_d;
      // Re-arms to 1 whenever we are outside EXEC, so it is 1 on entry.
      if (state == S_EXEC) ecnt <= ecnt + CW'(1);
      else                 ecnt <= CW'(1);
    end
  end

  always_comb begin
    state_d    = state;
    load_inst  = 1'b0;
    latch_wb   = 1'b0;
    pc_inc     = 1'b0;
    retire_inc = 1'b0;
    halt_set   = 1'b0;
    code_d     = 3'd0;
    unique case (state)
      S_IDLE:  if (run) state_d = S_FREQ;
      S_FREQ:  if (ifu.ifu_req_ready) state_d = S_FWAIT;
      S_FWAIT: begin
        if (ifu.ifu_rsp_valid) begin
          if (ifu.ifu_rsp_err) begin
            state_d  = S_HALT;
            halt_set = 1'b1;
            code_d   = 3'd3;
          end else begin
            load_inst = 1'b1;
            state_d   = S_DEC;
          end
        end
      end
      S_DEC: begin
        if (dec_illegal) begin
          state_d  = S_HALT;
          halt_set = 1'b1;
          code_d   = 3'd2;
        end else if (dec_ebreak) begin
          // ebreak counts as retired but does not advance the PC.
          state_d    = S_HALT;
          halt_set   = 1'b1;
          code_d     = 3'd1;
          retire_inc = 1'b1;
        end else begin
          latch_wb = 1'b1;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exu_done) begin
          state_d = S_WB;
        end else if (ecnt == TO) begin
          state_d  = S_HALT;
          halt_set = 1'b1;
          code_d   = 3'd4;
        end
      end
      S_WB: begin
        pc_inc     = 1'b1;
        retire_inc = 1'b1;
        state_d    = run ? S_FREQ : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  assign ifu.ifu_req_valid = (state == S_FREQ);
  assign ifu.ifu_req_addr  = pc;
  assign exu_start         = (state == S_EXEC) && (ecnt == CW'(1));
  assign regw_en           = (state == S_WB) && wb_pending;
  assign halted            = (state == S_HALT);

endmodule
